// File: rtl/seg_scan.sv
// seg_scan: multiplexed seven-segment scanner; define SEG_SCAN_BLANK_EN for a dark anti-ghosting interval per slot
module seg_scan #(
   parameter int NUM_DIGITS   = 8,
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] segs_i [7:0],
   input  logic       en_i,
   output logic [7:0] seg_o,
   output logic [7:0] an_o,
   output logic [2:0] digit_o,
   output logic       frame_o
);
   localparam int CW = $clog2(SCAN_DIV);
`ifdef SEG_SCAN_BLANK_EN
   typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
   localparam state_t FIRST = BLANK;
`else
   typedef enum logic [1:0] {IDLE, SHOW} state_t;
   localparam state_t FIRST = SHOW;
`endif
   if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || SCAN_DIV < 2 || BLANK_CYCLES < 1 || BLANK_CYCLES >= SCAN_DIV) begin : g_bad
      $error("seg_scan: parameter out of range");
   end
   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [2:0]      dig_n;
   logic [7:0]      shadow [7:0];
   logic [7:0]      an_n, seg_n;
   logic            wrap, last, load, frame_n;
   // next state, slot/digit counters and the output values they imply, so every output is a plain register
   always_comb begin
      wrap    = cnt == CW'(SCAN_DIV - 1);
      last    = digit_o == 3'(NUM_DIGITS - 1);
      state_n = IDLE;
      cnt_n   = '0;
      dig_n   = '0;
      load    = 1'b0;
      frame_n = 1'b0;
      if (en_i && state == IDLE) begin
         state_n = FIRST;
         load    = 1'b1;
      end else if (en_i) begin
         cnt_n   = wrap ? '0 : cnt + CW'(1);
         dig_n   = wrap ? (last ? 3'd0 : digit_o + 3'd1) : digit_o;
         load    = wrap && last;
         frame_n = load;
`ifdef SEG_SCAN_BLANK_EN
         state_n = wrap ? FIRST : (state == BLANK && cnt_n == CW'(BLANK_CYCLES)) ? SHOW : state;
`else
         state_n = SHOW;
`endif
      end
      an_n  = state_n == SHOW ? ~(8'd1 << dig_n) : 8'hFF;
      seg_n = state_n == SHOW ? (load ? segs_i[dig_n] : shadow[dig_n]) : 8'hFF;
   end
   // state and output registers; reset darkens the display without waiting for a clock
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= IDLE;
         cnt     <= '0;
         digit_o <= '0;
         frame_o <= 1'b0;
         an_o    <= 8'hFF;
         seg_o   <= 8'hFF;
         shadow  <= '{default: 8'hFF};
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         digit_o <= dig_n;
         frame_o <= frame_n;
         an_o    <= an_n;
         seg_o   <= seg_n;
         if (load) shadow <= segs_i;
      end
   end
endmodule
